mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the CPU's external bus: serves the CPU's 32-bit instruction fetch and 16-bit data read/write from a single 16-bit synchronous SRAM port. Sits between the CPU's `e_prog_addr`/`e_instr` and `e_addr_bus`/`e_data`/`e_mem_bus` pins and the board SRAM. Arbitrates between data and fetch, splits each fetch into two halfword accesses, inserts programmable wait states, and stalls the CPU until results are valid.

## Interface
- `WAIT_STATES`, default 1: extra SRAM cycles per access; each access lasts `WAIT_STATES+1` cycles; legal range 0..7.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `instr_req` in 1: level request for a fetch at `prog_addr`.
- `prog_addr` in 16: instruction word address.
- `instr` out 32: fetched instruction; low halfword is `[15:0]`.
- `instr_valid` out 1: one-cycle pulse when `instr` is updated.
- `d_re` in 1: data read request.
- `d_we` in 1: data write request.
- `d_addr` in 16: data halfword address (CPU `e_addr_bus`).
- `d_wdata` in 16: write data (CPU `e_data`).
- `d_rdata` out 16: read data (to CPU `e_mem_bus`).
- `d_valid` out 1: one-cycle pulse when a read result or write completion is available.
- `cpu_stall` out 1: CPU must hold its state while high.
- `sram_addr` out 18: `{1'b1, prog_addr, half}` for fetch, `{2'b00, d_addr}` for data.
- `sram_wdata` out 16: SRAM write data.
- `sram_we` out 1: SRAM write strobe.
- `sram_oe` out 1: SRAM read enable.
- `sram_rdata` in 16: SRAM read data, valid during the last cycle of a read access.

## Operation
- FSM states:
  - IDLE: on a sampled request, goes to D_ACC if `d_re|d_we`, else to I_LO if `instr_req`.
  - D_ACC: data access. On completion, goes to I_LO if `instr_req` is still high, else to DONE.
  - I_LO: reads halfword 0 into `instr[15:0]`, then goes to I_HI.
  - I_HI: reads halfword 1 into `instr[31:16]`, then goes to DONE.
  - DONE: one cycle, then returns to IDLE.
- Data has priority over fetch. The data access belongs to the current instruction; the fetch is for the next one.
- When `d_we` and `d_re` are both high, it is treated as a write; `d_rdata` is unchanged.
- Request inputs are captured into internal registers on the accept edge. Changes to them mid-transaction are ignored.
- Wait-state counter: loads 0 on entry to an access state and increments each cycle. The access ends in the cycle where `cnt == WAIT_STATES`.
- Read data is latched from `sram_rdata` on the edge that ends the access.
- `sram_oe` is high during every read-access cycle. `sram_we` is high during every write-access cycle. The two are never high together.
- `sram_addr` and `sram_wdata` are stable for the whole access.
- `instr` and `d_rdata` hold their values until the next completion of the same kind.
- `cpu_stall` = (state != IDLE && state != DONE) | (state == IDLE & (instr_req | d_re | d_we)).
  - It is low in DONE.
  - The CPU must drop or replace its requests by the edge ending DONE. Any request high in the following IDLE cycle is a new transaction.
- Reset values: state = IDLE, `cnt` = 0, `instr` = 0, `d_rdata` = 0, `instr_valid` = 0, `d_valid` = 0, `sram_we` = 0, `sram_oe` = 0, `sram_addr` = 0, `sram_wdata` = 0. `cpu_stall` is then combinational from the requests.
- Reset mid-transaction: on the reset edge, the FSM returns to IDLE and all strobes drop. No valid pulse is produced. An interrupted write may leave the addressed SRAM word undefined.

## Timing
- Let W = `WAIT_STATES`. Edge n is the edge on which IDLE samples the request.
- Data only:
  - Access cycles n+1 .. n+W+1.
  - `d_valid` and `d_rdata` visible in cycle n+W+2, which is the DONE cycle.
  - `cpu_stall` is high in cycles n .. n+W+1.
- Fetch only:
  - I_LO occupies cycles n+1 .. n+W+1.
  - I_HI occupies cycles n+W+2 .. n+2W+2.
  - `instr_valid` is visible in cycle n+2W+3.
- Data and fetch together:
  - `d_valid` pulses in the first I_LO cycle.
  - `instr_valid` pulses in cycle n+3W+4, which is the DONE cycle.
- All outputs except `cpu_stall` are registered.
- Back-to-back throughput: one transaction per (access cycles + 2).

## Structure
- The shared package/header defines:
  - the state encodings (IDLE, D_ACC, I_LO, I_HI, DONE, 3 bits);
  - the region-select constants `REGION_PROG = 2'b1x` and `REGION_DATA = 2'b00`;
  - the maximum `WAIT_STATES` value.
- One sub-module, `sram_access_timer`:
  - inputs: `clk`, `rst`, `start`, `wait_states`;
  - outputs: `busy`, `last`;
  - contains the 3-bit counter.
- The FSM, arbitration and datapath latches live in `mem_responder`.

## Test plan
- W=1, SRAM preloaded with data[0x0040] = 0xBEEF. Pulse `d_re`, `d_addr` = 0x0040 -> `sram_addr` = 0x00040 with `sram_oe` high for 2 cycles; `d_valid` and `d_rdata` = 0xBEEF 3 cycles after accept; `cpu_stall` high for exactly 3 cycles.
- W=1, `d_we` with `d_addr` = 0x0012 and `d_wdata` = 0x1234 -> `sram_we` high for 2 cycles at `sram_addr` = 0x00012 with `sram_wdata` = 0x1234; a readback returns 0x1234.
- W=0, `instr_req` with `prog_addr` = 0x0005, SRAM[0x2000A] = 0x00AA, SRAM[0x2000B] = 0x1100 -> `instr` = 0x110000AA with `instr_valid` 3 cycles after accept.
- W=2, `d_re` and `instr_req` asserted together -> data access first, then both fetch halves; `d_valid` at cycle 4, `instr_valid` at cycle 10; `cpu_stall` never drops in between.
- `d_re` and `d_we` both high -> write performed; `d_rdata` unchanged; `sram_oe` stays 0 throughout.
- Assert `rst` in I_LO during a W=3 fetch, then `rst` mid-write -> next cycle in IDLE with all strobes 0 and no valid pulse; a new fetch afterwards completes normally.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the CPU-side SRAM responder: FSM encodings, SRAM
// region selects and the wait-state limit.
package mem_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_D_ACC = 3'd1,
    ST_I_LO  = 3'd2,
    ST_I_HI  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int MAX_WAIT_STATES = 7;
  localparam int CNT_W           = $clog2(MAX_WAIT_STATES + 1);

  // Program region is 2'b1x: only the msb is decoded, bit 16 is prog_addr[15].
  localparam logic       REGION_PROG = 1'b1;
  localparam logic [1:0] REGION_DATA = 2'b00;

  function automatic logic [17:0] prog_sram_addr(input logic [15:0] addr, input logic half);
    return {REGION_PROG, addr, half};
  endfunction

  function automatic logic [17:0] data_sram_addr(input logic [15:0] addr);
    return {REGION_DATA, addr};
  endfunction

endpackage

// File: rtl/sram_access_timer.sv
// Counts the cycles of one SRAM access; o_last flags the final cycle.
// A start in the last cycle chains straight into the next access.
module sram_access_timer
  import mem_responder_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_wait_states,
  output logic             o_busy,
  output logic             o_last
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (o_last) begin
        r_cnt  <= '0;
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_busy = r_busy;
  assign o_last = r_busy && (r_cnt == i_wait_states);

endmodule

// File: rtl/mem_responder.sv
// Serves CPU 32-bit fetches and 16-bit data accesses from one 16-bit SRAM
// port; data wins arbitration, fetches are split into two halfword reads.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WAIT_STATES = 1  // legal range 0..MAX_WAIT_STATES
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_instr_req,
  input  logic [15:0] i_prog_addr,
  output logic [31:0] o_instr,
  output logic        o_instr_valid,
  input  logic        i_d_re,
  input  logic        i_d_we,
  input  logic [15:0] i_d_addr,
  input  logic [15:0] i_d_wdata,
  output logic [15:0] o_d_rdata,
  output logic        o_d_valid,
  output logic        o_cpu_stall,
  output logic [17:0] o_sram_addr,
  output logic [15:0] o_sram_wdata,
  output logic        o_sram_we,
  output logic        o_sram_oe,
  input  logic [15:0] i_sram_rdata
);

  localparam logic [CNT_W-1:0] WS = CNT_W'(WAIT_STATES);

  state_t      r_state;
  logic        r_is_write;
  logic [15:0] r_prog_addr;
  logic [15:0] r_instr_lo;

  logic w_any_req;
  logic w_timer_start;
  logic w_timer_busy;
  logic w_timer_last;
  logic w_access_done;

  assign w_any_req     = i_instr_req | i_d_re | i_d_we;
  assign w_access_done = w_timer_busy & w_timer_last;

  // Every transition into an access state restarts the wait-state counter.
  assign w_timer_start = (r_state == ST_IDLE  && w_any_req) ||
                         (r_state == ST_D_ACC && w_access_done && i_instr_req) ||
                         (r_state == ST_I_LO  && w_access_done);

  assign o_cpu_stall = (r_state != ST_IDLE && r_state != ST_DONE) ||
                       (r_state == ST_IDLE && w_any_req);

  sram_access_timer u_timer (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (w_timer_start),
    .i_wait_states (WS),
    .o_busy        (w_timer_busy),
    .o_last        (w_timer_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_is_write    <= 1'b0;
      r_prog_addr   <= '0;
      r_instr_lo    <= '0;
      o_instr       <= '0;
      o_instr_valid <= 1'b0;
      o_d_rdata     <= '0;
      o_d_valid     <= 1'b0;
      o_sram_addr   <= '0;
      o_sram_wdata  <= '0;
      o_sram_we     <= 1'b0;
      o_sram_oe     <= 1'b0;
    end else begin
      o_d_valid     <= 1'b0;
      o_instr_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_d_re || i_d_we) begin
            // A simultaneous read and write is treated as a write.
            r_state      <= ST_D_ACC;
            r_is_write   <= i_d_we;
            r_prog_addr  <= i_prog_addr;
            o_sram_addr  <= data_sram_addr(i_d_addr);
            o_sram_wdata <= i_d_wdata;
            o_sram_we    <= i_d_we;
            o_sram_oe    <= ~i_d_we;
          end else if (i_instr_req) begin
            r_state     <= ST_I_LO;
            r_prog_addr <= i_prog_addr;
            o_sram_addr <= prog_sram_addr(i_prog_addr, 1'b0);
            o_sram_we   <= 1'b0;
            o_sram_oe   <= 1'b1;
          end
        end
        ST_D_ACC: begin
          if (w_access_done) begin
            o_d_valid <= 1'b1;
            if (!r_is_write) o_d_rdata <= i_sram_rdata;
            if (i_instr_req) begin
              r_state     <= ST_I_LO;
              o_sram_addr <= prog_sram_addr(r_prog_addr, 1'b0);
              o_sram_we   <= 1'b0;
              o_sram_oe   <= 1'b1;
            end else begin
              r_state   <= ST_DONE;
              o_sram_we <= 1'b0;
              o_sram_oe <= 1'b0;
            end
          end
        end
        ST_I_LO: begin
          if (w_access_done) begin
            r_instr_lo  <= i_sram_rdata;
            r_state     <= ST_I_HI;
            o_sram_addr <= prog_sram_addr(r_prog_addr, 1'b1);
          end
        end
        ST_I_HI: begin
          if (w_access_done) begin
            o_instr       <= {i_sram_rdata, r_instr_lo};
            o_instr_valid <= 1'b1;
            r_state       <= ST_DONE;
            o_sram_oe     <= 1'b0;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: four responders (WAIT_STATES 0..3) share stimulus, each
// with its own SRAM model; every scenario checks the instance it targets.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req, d_re, d_we;
  logic [15:0] prog_addr, d_addr, d_wdata;

  logic [31:0] instr_o       [4];
  logic        instr_valid_o [4];
  logic [15:0] d_rdata_o     [4];
  logic        d_valid_o     [4];
  logic        stall_o       [4];
  logic [17:0] sram_addr_o   [4];
  logic [15:0] sram_wdata_o  [4];
  logic        sram_we_o     [4];
  logic        sram_oe_o     [4];
  logic [15:0] sram_rdata_i  [4];

  logic [15:0] mem [4][262144];
  logic        pl_en;
  logic [17:0] pl_addr;
  logic [15:0] pl_data;

  int total = 0;
  int bad   = 0;

  localparam int MAXC = 32;
  int          v_d_idx, v_i_idx, n_oe, n_we, n_stall, n_dv, n_iv;
  logic [17:0] rec_addr  [MAXC];
  logic [15:0] rec_wdata [MAXC];
  logic [15:0] rec_drdata;
  logic [31:0] rec_instr;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_responder #(.WAIT_STATES(g)) u_dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_instr_req   (instr_req),
      .i_prog_addr   (prog_addr),
      .o_instr       (instr_o[g]),
      .o_instr_valid (instr_valid_o[g]),
      .i_d_re        (d_re),
      .i_d_we        (d_we),
      .i_d_addr      (d_addr),
      .i_d_wdata     (d_wdata),
      .o_d_rdata     (d_rdata_o[g]),
      .o_d_valid     (d_valid_o[g]),
      .o_cpu_stall   (stall_o[g]),
      .o_sram_addr   (sram_addr_o[g]),
      .o_sram_wdata  (sram_wdata_o[g]),
      .o_sram_we     (sram_we_o[g]),
      .o_sram_oe     (sram_oe_o[g]),
      .i_sram_rdata  (sram_rdata_i[g])
    );
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (sram_we_o[k]) mem[k][sram_addr_o[k]] <= sram_wdata_o[k];
      if (pl_en) mem[k][pl_addr] <= pl_data;
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) sram_rdata_i[k] = mem[k][sram_addr_o[k]];
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drop_reqs;
    instr_req = 1'b0;
    d_re      = 1'b0;
    d_we      = 1'b0;
  endtask

  task automatic do_reset;
    drop_reqs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic preload(input logic [17:0] a, input logic [15:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  // Records per-cycle observations of instance g; cycle 0 is the accept cycle.
  task automatic run_txn(input int g, input bit wait_instr, input int ncyc);
    v_d_idx = -1; v_i_idx = -1;
    n_oe = 0; n_we = 0; n_stall = 0; n_dv = 0; n_iv = 0;
    #1;
    for (int c = 0; c < ncyc; c++) begin
      rec_addr[c]  = sram_addr_o[g];
      rec_wdata[c] = sram_wdata_o[g];
      if (stall_o[g])   n_stall++;
      if (sram_oe_o[g]) n_oe++;
      if (sram_we_o[g]) n_we++;
      if (d_valid_o[g]) begin
        n_dv++;
        if (v_d_idx < 0) begin
          v_d_idx    = c;
          rec_drdata = d_rdata_o[g];
          if (!wait_instr) drop_reqs();
        end
      end
      if (instr_valid_o[g]) begin
        n_iv++;
        if (v_i_idx < 0) begin
          v_i_idx   = c;
          rec_instr = instr_o[g];
          drop_reqs();
        end
      end
      step();
    end
  endtask

  task automatic test_reset;
    do_reset();
    for (int g = 0; g < 4; g++) begin
      total++; if (instr_o[g] !== 32'h0) begin bad++; $display("FAIL reset_instr[%0d]: got %h want 0", g, instr_o[g]); end
      total++; if (d_rdata_o[g] !== 16'h0) begin bad++; $display("FAIL reset_d_rdata[%0d]: got %h want 0", g, d_rdata_o[g]); end
      total++; if (instr_valid_o[g] !== 1'b0 || d_valid_o[g] !== 1'b0) begin bad++; $display("FAIL reset_valids[%0d]: got %b%b want 00", g, instr_valid_o[g], d_valid_o[g]); end
      total++; if (sram_we_o[g] !== 1'b0 || sram_oe_o[g] !== 1'b0) begin bad++; $display("FAIL reset_strobes[%0d]: got %b%b want 00", g, sram_we_o[g], sram_oe_o[g]); end
      total++; if (sram_addr_o[g] !== 18'h0 || sram_wdata_o[g] !== 16'h0) begin bad++; $display("FAIL reset_addr_wdata[%0d]: got %h/%h want 0/0", g, sram_addr_o[g], sram_wdata_o[g]); end
      total++; if (stall_o[g] !== 1'b0) begin bad++; $display("FAIL reset_stall_idle[%0d]: got %b want 0", g, stall_o[g]); end
    end
    d_re = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      total++; if (stall_o[g] !== 1'b1) begin bad++; $display("FAIL reset_stall_req[%0d]: got %b want 1", g, stall_o[g]); end
    end
    d_re = 1'b0;
  endtask

  task automatic test_data_read;
    do_reset();
    d_addr = 16'h0040; d_re = 1'b1;
    run_txn(1, 1'b0, 8);
    total++; if (v_d_idx !== 3) begin bad++; $display("FAIL rd_valid_cycle: got %0d want 3", v_d_idx); end
    total++; if (rec_drdata !== 16'hBEEF) begin bad++; $display("FAIL rd_data: got %h want beef", rec_drdata); end
    total++; if (n_oe !== 2 || n_we !== 0) begin bad++; $display("FAIL rd_strobes: got oe=%0d we=%0d want 2/0", n_oe, n_we); end
    total++; if (n_stall !== 3) begin bad++; $display("FAIL rd_stall_cycles: got %0d want 3", n_stall); end
    total++; if (rec_addr[1] !== 18'h00040 || rec_addr[2] !== 18'h00040) begin bad++; $display("FAIL rd_addr: got %h/%h want 00040", rec_addr[1], rec_addr[2]); end
    total++; if (n_dv !== 1) begin bad++; $display("FAIL rd_single_pulse: got %0d want 1", n_dv); end
  endtask

  task automatic test_data_write;
    do_reset();
    d_addr = 16'h0012; d_wdata = 16'h1234; d_we = 1'b1;
    run_txn(1, 1'b0, 8);
    total++; if (n_we !== 2 || n_oe !== 0) begin bad++; $display("FAIL wr_strobes: got we=%0d oe=%0d want 2/0", n_we, n_oe); end
    total++; if (rec_addr[1] !== 18'h00012 || rec_addr[2] !== 18'h00012) begin bad++; $display("FAIL wr_addr: got %h/%h want 00012", rec_addr[1], rec_addr[2]); end
    total++; if (rec_wdata[1] !== 16'h1234 || rec_wdata[2] !== 16'h1234) begin bad++; $display("FAIL wr_wdata: got %h/%h want 1234", rec_wdata[1], rec_wdata[2]); end
    total++; if (v_d_idx !== 3) begin bad++; $display("FAIL wr_valid_cycle: got %0d want 3", v_d_idx); end
    total++; if (rec_drdata !== 16'h0000) begin bad++; $display("FAIL wr_rdata_held: got %h want 0", rec_drdata); end
    d_addr = 16'h0012; d_re = 1'b1;
    run_txn(1, 1'b0, 8);
    total++; if (rec_drdata !== 16'h1234 || v_d_idx !== 3) begin bad++; $display("FAIL wr_readback: got %h@%0d want 1234@3", rec_drdata, v_d_idx); end
  endtask

  task automatic test_fetch;
    do_reset();
    prog_addr = 16'h0005; instr_req = 1'b1;
    run_txn(0, 1'b1, 8);
    total++; if (v_i_idx !== 3) begin bad++; $display("FAIL fetch_valid_cycle: got %0d want 3", v_i_idx); end
    total++; if (rec_instr !== 32'h110000AA) begin bad++; $display("FAIL fetch_instr: got %h want 110000aa", rec_instr); end
    total++; if (rec_addr[1] !== 18'h2000A || rec_addr[2] !== 18'h2000B) begin bad++; $display("FAIL fetch_addr: got %h/%h want 2000a/2000b", rec_addr[1], rec_addr[2]); end
    total++; if (n_oe !== 2 || n_stall !== 3 || n_iv !== 1) begin bad++; $display("FAIL fetch_counts: got oe=%0d stall=%0d iv=%0d want 2/3/1", n_oe, n_stall, n_iv); end
  endtask

  task automatic test_data_and_fetch;
    do_reset();
    d_addr = 16'h0040; d_re = 1'b1;
    prog_addr = 16'h0005; instr_req = 1'b1;
    run_txn(2, 1'b1, 16);
    total++; if (v_d_idx !== 4) begin bad++; $display("FAIL both_d_valid_cycle: got %0d want 4", v_d_idx); end
    total++; if (v_i_idx !== 10) begin bad++; $display("FAIL both_i_valid_cycle: got %0d want 10", v_i_idx); end
    total++; if (n_stall !== 10) begin bad++; $display("FAIL both_stall_cycles: got %0d want 10", n_stall); end
    total++; if (rec_drdata !== 16'hBEEF || rec_instr !== 32'h110000AA) begin bad++; $display("FAIL both_data: got %h/%h want beef/110000aa", rec_drdata, rec_instr); end
    total++; if (n_oe !== 9) begin bad++; $display("FAIL both_oe_cycles: got %0d want 9", n_oe); end
    total++; if (rec_addr[3] !== 18'h00040 || rec_addr[4] !== 18'h2000A || rec_addr[7] !== 18'h2000B) begin bad++; $display("FAIL both_addr_order: got %h/%h/%h want 00040/2000a/2000b", rec_addr[3], rec_addr[4], rec_addr[7]); end
  endtask

  task automatic test_rw_both;
    do_reset();
    d_addr = 16'h0040; d_re = 1'b1;
    run_txn(1, 1'b0, 6);
    d_addr = 16'h0020; d_wdata = 16'h5A5A; d_re = 1'b1; d_we = 1'b1;
    run_txn(1, 1'b0, 6);
    total++; if (n_oe !== 0 || n_we !== 2) begin bad++; $display("FAIL rw_strobes: got oe=%0d we=%0d want 0/2", n_oe, n_we); end
    total++; if (rec_drdata !== 16'hBEEF || v_d_idx !== 3) begin bad++; $display("FAIL rw_rdata_held: got %h@%0d want beef@3", rec_drdata, v_d_idx); end
    total++; if (mem[1][18'h00020] !== 16'h5A5A) begin bad++; $display("FAIL rw_sram_word: got %h want 5a5a", mem[1][18'h00020]); end
  endtask

  task automatic test_reset_mid;
    int pulses;
    do_reset();
    prog_addr = 16'h0005; instr_req = 1'b1;
    step();
    total++; if (sram_oe_o[3] !== 1'b1 || sram_addr_o[3] !== 18'h2000A) begin bad++; $display("FAIL mid_in_ilo: got oe=%b addr=%h want 1/2000a", sram_oe_o[3], sram_addr_o[3]); end
    rst = 1'b1; drop_reqs();
    step();
    total++; if (sram_oe_o[3] !== 1'b0 || sram_we_o[3] !== 1'b0 || sram_addr_o[3] !== 18'h0 || stall_o[3] !== 1'b0) begin bad++; $display("FAIL mid_fetch_abort: got oe=%b we=%b addr=%h stall=%b want 0/0/0/0", sram_oe_o[3], sram_we_o[3], sram_addr_o[3], stall_o[3]); end
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (d_valid_o[3] || instr_valid_o[3]) pulses++;
      step();
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL mid_fetch_no_valid: got %0d want 0", pulses); end
    d_addr = 16'h0030; d_wdata = 16'h7777; d_we = 1'b1;
    step();
    step();
    total++; if (sram_we_o[3] !== 1'b1) begin bad++; $display("FAIL mid_in_write: got we=%b want 1", sram_we_o[3]); end
    rst = 1'b1; drop_reqs();
    step();
    total++; if (sram_we_o[3] !== 1'b0 || sram_oe_o[3] !== 1'b0 || d_valid_o[3] !== 1'b0) begin bad++; $display("FAIL mid_write_abort: got we=%b oe=%b dv=%b want 0/0/0", sram_we_o[3], sram_oe_o[3], d_valid_o[3]); end
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (d_valid_o[3] || instr_valid_o[3]) pulses++;
      step();
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL mid_write_no_valid: got %0d want 0", pulses); end
    prog_addr = 16'h0005; instr_req = 1'b1;
    run_txn(3, 1'b1, 16);
    total++; if (v_i_idx !== 9 || rec_instr !== 32'h110000AA) begin bad++; $display("FAIL mid_refetch: got %h@%0d want 110000aa@9", rec_instr, v_i_idx); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    prog_addr = '0; d_addr = '0; d_wdata = '0;
    drop_reqs();
    step();
    preload(18'h00040, 16'hBEEF);
    preload(18'h2000A, 16'h00AA);
    preload(18'h2000B, 16'h1100);
    test_reset();
    test_data_read();
    test_data_write();
    test_fetch();
    test_data_and_fetch();
    test_rw_both();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
